fetch_unit: RTL

Instruction fetch stage feeding the decoder/execution pipeline of the 32-bit AAP core. Holds the program counter, reads 16-bit halfwords from a synchronous program memory and assembles 16- or 32-bit instructions. Consumes the redirect outputs of the execution stage (`pcjumpenable`, `pcchange`, `pclocation`) and supplies the `previous_programcounter` link value.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, synchronous halfword fetch and
// assembly of 16/32-bit instructions, with redirect handling from execute.
module fetch_unit #(
  parameter int PC_WIDTH = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic [2:0]          pcjumpenable,
  input  logic [8:0]          pcchange,
  input  logic [5:0]          pclocation,
  input  logic [PC_WIDTH-1:0] branch_pc,
  output logic [PC_WIDTH-1:0] prog_rd,
  input  logic [15:0]         prog_rd_out,
  output logic [31:0]         instruction,
  output logic                instruction_valid,
  output logic [PC_WIDTH-1:0] programcounter,
  output logic [PC_WIDTH-1:0] previous_programcounter
);

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] PC_TWO = {{(PC_WIDTH-2){1'b0}}, 2'b10};

  state_t              state_r;
  state_t              state_next_s;
  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic [PC_WIDTH-1:0] resp_pc_r;
  logic                resp_valid_r;
  logic [15:0]         hold_lo_r;
  logic [PC_WIDTH-1:0] hold_pc_r;
  logic [31:0]         instruction_r;
  logic                instruction_valid_r;
  logic [PC_WIDTH-1:0] programcounter_r;
  logic [PC_WIDTH-1:0] previous_programcounter_r;

  logic                redirect_s;
  logic [PC_WIDTH-1:0] target_s;
  logic [PC_WIDTH-1:0] offset_ext_s;
  logic                advance_s;
  logic                assemble_s;
  logic                issue_s;
  logic                capture_s;
  logic [31:0]         issue_instr_s;
  logic [PC_WIDTH-1:0] issue_pc_s;
  logic [PC_WIDTH-1:0] issue_prev_s;

  assign offset_ext_s = {{(PC_WIDTH-9){pcchange[8]}}, pcchange};
  assign advance_s    = !redirect_s && !stall;
  assign assemble_s   = advance_s && resp_valid_r;

  // While stalled, re-request the in-flight address so returning data stays aligned with resp_pc.
  assign prog_rd = stall ? resp_pc_r : fetch_pc_r;

  // Redirect decode: relative codes add a signed halfword offset, absolute codes zero-extend.
  always_comb begin
    redirect_s = 1'b0;
    target_s   = {PC_WIDTH{1'b0}};
    case (pcjumpenable)
      3'd1, 3'd4: begin
        redirect_s = 1'b1;
        target_s   = branch_pc + offset_ext_s;
      end
      3'd2, 3'd3: begin
        redirect_s = 1'b1;
        target_s   = {{(PC_WIDTH-6){1'b0}}, pclocation};
      end
      default: begin
        redirect_s = 1'b0;
        target_s   = {PC_WIDTH{1'b0}};
      end
    endcase
  end

  // Assembly state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_LOW;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: a redirect always abandons any half-built 32-bit instruction.
  always_comb begin
    state_next_s = state_r;
    if (redirect_s) begin
      state_next_s = ST_LOW;
    end else if (assemble_s) begin
      case (state_r)
        ST_LOW:  state_next_s = prog_rd_out[15] ? ST_HIGH : ST_LOW;
        ST_HIGH: state_next_s = ST_LOW;
        default: state_next_s = ST_LOW;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Assembly outputs: what to issue or capture for the halfword returning this cycle.
  always_comb begin
    issue_s       = 1'b0;
    capture_s     = 1'b0;
    issue_instr_s = 32'h0000_0000;
    issue_pc_s    = {PC_WIDTH{1'b0}};
    issue_prev_s  = {PC_WIDTH{1'b0}};
    if (assemble_s) begin
      case (state_r)
        ST_LOW: begin
          if (prog_rd_out[15]) begin
            capture_s = 1'b1;
          end else begin
            issue_s       = 1'b1;
            issue_instr_s = {16'h0000, prog_rd_out};
            issue_pc_s    = resp_pc_r;
            issue_prev_s  = resp_pc_r + PC_ONE;
          end
        end
        ST_HIGH: begin
          issue_s       = 1'b1;
          issue_instr_s = {prog_rd_out, hold_lo_r};
          issue_pc_s    = hold_pc_r;
          issue_prev_s  = hold_pc_r + PC_TWO;
        end
        default: begin
          issue_s   = 1'b0;
          capture_s = 1'b0;
        end
      endcase
    end else begin
      issue_s   = 1'b0;
      capture_s = 1'b0;
    end
  end

  // Fetch pointers, holding registers and registered instruction outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_r                <= {PC_WIDTH{1'b0}};
      resp_pc_r                 <= {PC_WIDTH{1'b0}};
      resp_valid_r              <= 1'b0;
      hold_lo_r                 <= 16'h0000;
      hold_pc_r                 <= {PC_WIDTH{1'b0}};
      instruction_r             <= 32'h0000_0000;
      instruction_valid_r       <= 1'b0;
      programcounter_r          <= {PC_WIDTH{1'b0}};
      previous_programcounter_r <= {PC_WIDTH{1'b0}};
    end else if (redirect_s) begin
      // resp_pc also takes the target so a stall straight after a redirect keeps requesting it.
      fetch_pc_r          <= target_s;
      resp_pc_r           <= target_s;
      resp_valid_r        <= 1'b0;
      instruction_valid_r <= 1'b0;
    end else if (stall) begin
      fetch_pc_r          <= fetch_pc_r;
      resp_pc_r           <= resp_pc_r;
      resp_valid_r        <= resp_valid_r;
      instruction_valid_r <= instruction_valid_r;
    end else begin
      resp_pc_r    <= fetch_pc_r;
      resp_valid_r <= 1'b1;
      fetch_pc_r   <= fetch_pc_r + PC_ONE;
      if (capture_s) begin
        hold_lo_r <= prog_rd_out;
        hold_pc_r <= resp_pc_r;
      end
      if (issue_s) begin
        instruction_r             <= issue_instr_s;
        programcounter_r          <= issue_pc_s;
        previous_programcounter_r <= issue_prev_s;
        instruction_valid_r       <= 1'b1;
      end else begin
        instruction_valid_r <= 1'b0;
      end
    end
  end

  assign instruction             = instruction_r;
  assign instruction_valid       = instruction_valid_r;
  assign programcounter          = programcounter_r;
  assign previous_programcounter = previous_programcounter_r;

endmodule
